// File: rtl/enc_filter.sv
// Quadrature encoder input conditioner.
// Each raw pin is synchronized into the clk domain and then digitally filtered:
// a filtered output only changes after the synced value has disagreed with it
// for FILT_LEN consecutive cycles. Flags report every output update and the
// illegal case of both channels updating on the same edge.
module enc_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 16
) (
  input  logic clk,
  input  logic nrst,
  input  logic enc_a_in,
  input  logic enc_b_in,
  input  logic err_clr,
  output logic enc_a,
  output logic enc_b,
  output logic changed,
  output logic dual_err,
  output logic err_sticky
);

  // One extra bit keeps FILT_LEN-1 representable for every legal FILT_LEN.
  localparam int CW = $clog2(FILT_LEN) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_LEN - 1);

  // Index 0 is channel A, index 1 is channel B throughout.
  logic [1:0]             raw;
  logic [SYNC_STAGES-1:0] sync_q [2];
  logic [CW-1:0]          cnt_q  [2];
  logic [1:0]             filt_q;
  logic [1:0]             upd;

  assign raw   = {enc_b_in, enc_a_in};
  assign enc_a = filt_q[0];
  assign enc_b = filt_q[1];

  // Synchronizer chains: shift the raw pin in at bit 0, the top bit is the synced value.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int ch = 0; ch < 2; ch++) begin
        sync_q[ch] <= '0;
      end
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        sync_q[ch] <= {sync_q[ch][SYNC_STAGES-2:0], raw[ch]};
      end
    end
  end

  // An update happens on the edge where a disagreement has already lasted FILT_LEN-1 cycles.
  always_comb begin
    upd = '0;
    for (int ch = 0; ch < 2; ch++) begin
      upd[ch] = (sync_q[ch][SYNC_STAGES-1] != filt_q[ch]) && (cnt_q[ch] == CNT_LAST);
    end
  end

  // Agreement counters and filtered outputs; any matching cycle restarts qualification.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int ch = 0; ch < 2; ch++) begin
        cnt_q[ch] <= '0;
      end
      filt_q <= '0;
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        if (sync_q[ch][SYNC_STAGES-1] == filt_q[ch]) begin
          cnt_q[ch] <= '0;
        end else if (upd[ch]) begin
          filt_q[ch] <= sync_q[ch][SYNC_STAGES-1];
          cnt_q[ch]  <= '0;
        end else begin
          cnt_q[ch] <= cnt_q[ch] + CW'(1);
        end
      end
    end
  end

  // Registered status flags; a same-edge dual update beats a clear request.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      changed    <= 1'b0;
      dual_err   <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      changed  <= |upd;
      dual_err <= &upd;
      if (&upd) begin
        err_sticky <= 1'b1;
      end else if (err_clr) begin
        err_sticky <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_enc_filter.sv
// Scoreboard bench for enc_filter with SYNC_STAGES=2, FILT_LEN=4.
// Stimulus pushes the expected update (edge number and output values) into a
// queue; the monitor pops one entry for every changed pulse it observes.
module tb_enc_filter;

  localparam int SYNC_STAGES = 2;
  localparam int FILT_LEN    = 4;
  // Input driven at the negedge after edge C is first sampled at edge C+1 and
  // reaches the output at edge C+1+2+4-1 = C+6.
  localparam int LAT = 6;

  typedef struct {
    int   cyc;
    logic a;
    logic b;
    logic dual;
  } exp_t;

  logic clk = 1'b0;
  logic nrst;
  logic enc_a_in;
  logic enc_b_in;
  logic err_clr;
  logic enc_a;
  logic enc_b;
  logic changed;
  logic dual_err;
  logic err_sticky;

  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  logic mod_a  = 1'b0;
  logic mod_b  = 1'b0;

  enc_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILT_LEN   (FILT_LEN)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .enc_a_in  (enc_a_in),
    .enc_b_in  (enc_b_in),
    .err_clr   (err_clr),
    .enc_a     (enc_a),
    .enc_b     (enc_b),
    .changed   (changed),
    .dual_err  (dual_err),
    .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, act, req, cyc);
    end
  endtask

  // Drive both pins at the current negedge; optionally record the expected update.
  task automatic applyStimulus(input logic a, input logic b, input bit expect_upd, input int hold);
    exp_t e;
    enc_a_in = a;
    enc_b_in = b;
    if (expect_upd) begin
      e.cyc  = cyc + LAT;
      e.a    = a;
      e.b    = b;
      e.dual = (a != mod_a) && (b != mod_b);
      exp_q.push_back(e);
      mod_a = a;
      mod_b = b;
    end
    repeat (hold) @(negedge clk);
  endtask

  // Monitor: every changed pulse must match the oldest expected update.
  always @(negedge clk) begin
    exp_t e;
    if (nrst) begin
      if (changed) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_changed: got changed=1 enc_a=%0d enc_b=%0d, expected no update (edge %0d)",
                   enc_a, enc_b, cyc);
        end else begin
          e = exp_q.pop_front();
          checkOutput("update_edge", cyc, e.cyc);
          checkOutput("update_value {a,b,dual}", {29'd0, enc_a, enc_b, dual_err}, {29'd0, e.a, e.b, e.dual});
        end
      end else if (dual_err) begin
        checks++;
        errors++;
        $display("[TB] FAIL dual_without_changed: got dual_err=1 changed=0, expected dual_err=0 (edge %0d)", cyc);
      end
    end
  end

  initial begin
    nrst     = 1'b0;
    enc_a_in = 1'b0;
    enc_b_in = 1'b0;
    err_clr  = 1'b0;
    #3;
    checkOutput("reset enc_a", enc_a, 0);
    checkOutput("reset enc_b", enc_b, 0);
    checkOutput("reset changed", changed, 0);
    checkOutput("reset dual_err", dual_err, 0);
    checkOutput("reset err_sticky", err_sticky, 0);
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    repeat (2) @(negedge clk);

    // Single channel rise: enc_a at LAT edges, no dual error.
    applyStimulus(1'b1, 1'b0, 1'b1, 10);
    applyStimulus(1'b0, 1'b0, 1'b1, 10);

    // Short pulses of 1, 2 and 3 cycles must be swallowed.
    for (int w = 1; w <= 3; w++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, w);
      applyStimulus(1'b0, 1'b0, 1'b0, 5);
    end
    checkOutput("short_pulse enc_a", enc_a, 0);

    // Both channels together: dual error and sticky flag, then clear.
    applyStimulus(1'b1, 1'b1, 1'b1, 10);
    checkOutput("sticky_after_dual", err_sticky, 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checkOutput("sticky_after_clr", err_sticky, 0);

    // Walk back to 00 legally, then the full quadrature cycle.
    applyStimulus(1'b1, 1'b0, 1'b1, 10);
    applyStimulus(1'b0, 1'b0, 1'b1, 10);
    applyStimulus(1'b0, 1'b1, 1'b1, 10);
    applyStimulus(1'b1, 1'b1, 1'b1, 10);
    applyStimulus(1'b1, 1'b0, 1'b1, 10);
    applyStimulus(1'b0, 1'b0, 1'b1, 10);
    checkOutput("quad_sticky", err_sticky, 0);
    checkOutput("quad_final {a,b}", {30'd0, enc_a, enc_b}, 0);

    // Dual error on the same edge as err_clr: set must win.
    applyStimulus(1'b1, 1'b1, 1'b1, LAT - 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checkOutput("sticky_set_wins", err_sticky, 1);
    repeat (4) @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b1, 10);
    checkOutput("pre_reset enc_a", enc_a, 1);
    checkOutput("pre_reset sticky", err_sticky, 1);

    // enc_b rise interrupted by reset when its counter has reached 2.
    applyStimulus(1'b1, 1'b1, 1'b0, 4);
    checkOutput("midqual enc_b", enc_b, 0);
    nrst     = 1'b0;
    enc_a_in = 1'b0;
    #1;
    checkOutput("in_reset {a,b,chg,dual,sticky}",
                {27'd0, enc_a, enc_b, changed, dual_err, err_sticky}, 0);
    mod_a = 1'b0;
    mod_b = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("held_reset enc_b", enc_b, 0);
    nrst = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b1, 10);
    checkOutput("post_reset enc_b", enc_b, 1);
    checkOutput("post_reset sticky", err_sticky, 0);

    repeat (5) @(negedge clk);
    checkOutput("pending_updates", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/enc_filter.md
ENC_FILTER -- requirements
Module: enc_filter

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth per channel; legal range 2..4.
REQ-002 SHALL have parameter FILT_LEN, default 16, consecutive-cycle agreement required before a filtered output updates; legal range 1..65535.
REQ-003 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-004 SHALL have port nrst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port enc_a_in  input  1  raw encoder channel A from pin, asynchronous to clk.
REQ-006 SHALL have port enc_b_in  input  1  raw encoder channel B from pin, asynchronous to clk.
REQ-007 SHALL have port err_clr  input  1  synchronous clear of err_sticky.
REQ-008 SHALL have port enc_a  output  1  filtered channel A, glitch-free, for the downstream quadrature decoder.
REQ-009 SHALL have port enc_b  output  1  filtered channel B, glitch-free.
REQ-010 SHALL have port changed  output  1  one-cycle pulse when enc_a or enc_b updates.
REQ-011 SHALL have port dual_err  output  1  one-cycle pulse when enc_a and enc_b update on the same edge (illegal quadrature step).
REQ-012 SHALL have port err_sticky  output  1  latched dual_err.

Function
REQ-013 SHALL pass each raw input through its own SYNC_STAGES-deep flip-flop chain; the last stage is the synced value.
REQ-014 SHALL keep one counter per channel, width ceil(log2(FILT_LEN))+1, plus one registered output per channel.
REQ-015 Per channel, each edge: synced == output -> counter <= 0; synced != output and counter < FILT_LEN-1 -> counter <= counter+1; synced != output and counter == FILT_LEN-1 -> output <= synced, counter <= 0.
REQ-016 A mismatch interrupted by even one matching cycle SHALL restart qualification from 0; pulses shorter than FILT_LEN synced cycles SHALL never reach the output.
REQ-017 Latency: a raw level first sampled at edge k and held stable SHALL appear on the output at edge k+SYNC_STAGES+FILT_LEN-1; FILT_LEN=1 gives pure synchronization.
REQ-018 Counters SHALL saturate by construction (reset to 0 on update) and never wrap.
REQ-019 changed SHALL be registered and asserted for exactly the cycle after the edge at which either output updated.
REQ-020 dual_err SHALL follow the same timing as changed and assert only when both outputs updated on the same edge; changed SHALL also assert in that cycle.
REQ-021 err_sticky SHALL set on the edge at which dual_err is generated and clear on an edge with err_clr=1; simultaneous set and clear -> set wins.
REQ-022 Channels SHALL be filtered independently; no cross-channel gating of updates.

Reset
REQ-023 On nrst low, all synchronizer flops, counters, enc_a, enc_b, changed, dual_err and err_sticky SHALL go to 0 immediately, independent of clk.
REQ-024 Release of nrst SHALL be handled without glitching outputs; the first update after release obeys REQ-015 from counter 0.
REQ-025 Reset asserted mid-qualification SHALL discard the partial count; a pending output update SHALL NOT occur.

Verification
REQ-026 SYNC_STAGES=2, FILT_LEN=4: raise enc_a_in before edge k, hold -> enc_a=1 from edge k+5, changed high one cycle, dual_err=0.
REQ-027 FILT_LEN=4: enc_a_in high-pulses of 1,2,3 clk cycles separated by 5 low cycles -> enc_a stays 0, changed never asserts.
REQ-028 FILT_LEN=4: toggle enc_a_in and enc_b_in together, hold -> both outputs update same edge, changed=1 and dual_err=1 one cycle, err_sticky=1 held; pulse err_clr -> err_sticky=0 next edge.
REQ-029 Full quadrature sequence 00->01->11->10->00, each step held 10 cycles, FILT_LEN=4 -> outputs follow in order, four changed pulses, zero dual_err.
REQ-030 Assert nrst at counter=2 during an enc_b rise, release -> all outputs 0 during reset; enc_b=1 only SYNC_STAGES+FILT_LEN-1 edges after the first post-reset sampling edge.
REQ-031 err_clr and a dual_err event on the same edge -> err_sticky=1.
